// File: rtl/noc_credit_tx_if.sv
// Flit link bundle: source-side handshake into the credit transmitter and the
// strobed flit/credit pair toward the downstream router input.
interface noc_credit_tx_if #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 1
);
    logic [FLIT_WIDTH-1:0] in_data;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;

    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    // Driver of flits and consumer of the router-side strobe.
    modport master (
        output in_data, in_dest, in_last, in_valid, credit_in,
        input  in_ready, data_out, dest_out, is_tail_out, send_out
    );

    // The transmitter itself.
    modport slave (
        input  in_data, in_dest, in_last, in_valid, credit_in,
        output in_ready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_credit_tx.sv
// Credit-based flit transmitter: forwards flits to a router input one cycle after
// acceptance, tracks downstream buffer credits and packet destination per packet.
module noc_credit_tx #(
    parameter int unsigned FLIT_WIDTH        = 32,
    parameter int unsigned DEST_WIDTH        = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4,
    localparam int unsigned CreditWidth      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noc_credit_tx_if.slave         link,
    output logic [CreditWidth-1:0] credits,
    output logic                   pkt_active,
    output logic                   credit_err
);
    localparam logic [CreditWidth-1:0] MaxCredits = CreditWidth'(FLIT_BUFFER_DEPTH);
    localparam logic [CreditWidth-1:0] CreditOne  = CreditWidth'(1);

    typedef enum logic {StIdle, StBody} state_e;

    state_e                 state_q, state_d;
    logic [CreditWidth-1:0] credits_q, credits_d;
    logic                   err_q, err_d;
    logic [DEST_WIDTH-1:0]  dest_lat_q;
    logic [FLIT_WIDTH-1:0]  data_q;
    logic [DEST_WIDTH-1:0]  dest_q;
    logic                   tail_q;
    logic                   send_q;
    logic [DEST_WIDTH-1:0]  dest_eff;
    logic                   transfer;

    // Ready depends only on registered credits, never on same-cycle inputs.
    assign link.in_ready = (credits_q != '0);
    assign transfer      = link.in_valid && link.in_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (transfer) begin
            unique case (state_q)
                StIdle:  state_d = link.in_last ? StIdle : StBody;
                StBody:  state_d = link.in_last ? StIdle : StBody;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: head flits take in_dest, body/tail flits reuse the latched one.
    always_comb begin
        pkt_active = (state_q == StBody);
        dest_eff   = (state_q == StIdle) ? link.in_dest : dest_lat_q;
    end

    // A simultaneous send and credit return cancel; overflow is sticky.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({transfer, link.credit_in})
            2'b10: credits_d = credits_q - CreditOne;
            2'b01: begin
                if (credits_q == MaxCredits) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CreditOne;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q  <= MaxCredits;
            err_q      <= 1'b0;
            dest_lat_q <= '0;
            data_q     <= '0;
            dest_q     <= '0;
            tail_q     <= 1'b0;
            send_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
            send_q    <= transfer;
            if (transfer) begin
                data_q <= link.in_data;
                dest_q <= dest_eff;
                tail_q <= link.in_last;
                if (state_q == StIdle) begin
                    dest_lat_q <= link.in_dest;
                end
            end
        end
    end

    assign link.data_out    = data_q;
    assign link.dest_out    = dest_q;
    assign link.is_tail_out = tail_q;
    assign link.send_out    = send_q;
    assign credits          = credits_q;
    assign credit_err       = err_q;
endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed bench for noc_credit_tx at DEPTH=4, DEST_WIDTH=1; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_noc_credit_tx;
    localparam int unsigned FW    = 32;
    localparam int unsigned DW    = 1;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] credits;
    logic       pkt_active;
    logic       credit_err;

    int total;
    int bad;

    noc_credit_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) link ();

    noc_credit_tx #(
        .FLIT_WIDTH       (FW),
        .DEST_WIDTH       (DW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .link      (link.slave),
        .credits   (credits),
        .pkt_active(pkt_active),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic dst, input logic l,
                         input logic cr);
        link.in_valid  = v;
        link.in_data   = d;
        link.in_dest   = dst;
        link.in_last   = l;
        link.credit_in = cr;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_send", {31'd0, link.send_out}, 32'd0);
        chk("rst_data", link.data_out, 32'd0);
        chk("rst_dest", {31'd0, link.dest_out}, 32'd0);
        chk("rst_tail", {31'd0, link.is_tail_out}, 32'd0);
        chk("rst_credits", {29'd0, credits}, 32'd4);
        chk("rst_pkt", {31'd0, pkt_active}, 32'd0);
        chk("rst_err", {31'd0, credit_err}, 32'd0);
        chk("rst_ready", {31'd0, link.in_ready}, 32'd1);
        #3 rst_n = 1'b1;
        tick();

        // Single-flit packet
        drive(1'b1, 32'h1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("single_send", {31'd0, link.send_out}, 32'd1);
        chk("single_data", link.data_out, 32'h1);
        chk("single_tail", {31'd0, link.is_tail_out}, 32'd1);
        chk("single_credits", {29'd0, credits}, 32'd3);
        drive(1'b0, 32'hdead, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold_send", {31'd0, link.send_out}, 32'd0);
        chk("hold_data", link.data_out, 32'h1);
        chk("hold_tail", {31'd0, link.is_tail_out}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("refill_credits", {29'd0, credits}, 32'd4);

        // Five flits with no credit return: only four go out
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h10 + k, 1'b0, 1'b1, 1'b0);
            tick();
            chk("burst_send", {31'd0, link.send_out}, 32'd1);
            chk("burst_data", link.data_out, 32'h10 + k);
            chk("burst_credits", {29'd0, credits}, 32'(3 - k));
        end
        chk("burst_ready0", {31'd0, link.in_ready}, 32'd0);
        drive(1'b1, 32'h14, 1'b0, 1'b1, 1'b0);
        tick();
        chk("stall_send", {31'd0, link.send_out}, 32'd0);
        chk("stall_credits", {29'd0, credits}, 32'd0);
        chk("stall_data", link.data_out, 32'h13);
        drive(1'b1, 32'h14, 1'b0, 1'b1, 1'b1);
        tick();
        chk("credit1_send", {31'd0, link.send_out}, 32'd0);
        chk("credit1_credits", {29'd0, credits}, 32'd1);
        drive(1'b1, 32'h14, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fifth_send", {31'd0, link.send_out}, 32'd1);
        chk("fifth_data", link.data_out, 32'h14);
        chk("fifth_credits", {29'd0, credits}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("burst_refill", {29'd0, credits}, 32'd4);
        chk("burst_err", {31'd0, credit_err}, 32'd0);

        // Three-flit packet: dest taken from head only
        drive(1'b1, 32'ha0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("head_dest", {31'd0, link.dest_out}, 32'd1);
        chk("head_tail", {31'd0, link.is_tail_out}, 32'd0);
        chk("head_pkt", {31'd0, pkt_active}, 32'd1);
        drive(1'b1, 32'ha1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("body_data", link.data_out, 32'ha1);
        chk("body_dest", {31'd0, link.dest_out}, 32'd1);
        chk("body_tail", {31'd0, link.is_tail_out}, 32'd0);
        chk("body_pkt", {31'd0, pkt_active}, 32'd1);
        drive(1'b1, 32'ha2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("tail_send", {31'd0, link.send_out}, 32'd1);
        chk("tail_dest", {31'd0, link.dest_out}, 32'd1);
        chk("tail_tail", {31'd0, link.is_tail_out}, 32'd1);
        chk("tail_pkt", {31'd0, pkt_active}, 32'd0);
        chk("tail_credits", {29'd0, credits}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        // Transfer and credit return together: count holds at 2
        drive(1'b1, 32'hb0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("pre_both_credits", {29'd0, credits}, 32'd2);
        tick();
        chk("both_credits", {29'd0, credits}, 32'd2);
        chk("both_send", {31'd0, link.send_out}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("full_credits", {29'd0, credits}, 32'd4);
        chk("full_err", {31'd0, credit_err}, 32'd0);
        tick();
        chk("ovf_credits", {29'd0, credits}, 32'd4);
        chk("ovf_err", {31'd0, credit_err}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf_sticky", {31'd0, credit_err}, 32'd1);

        // Reset mid-packet takes effect without a clock edge
        drive(1'b1, 32'hc0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid_pkt", {31'd0, pkt_active}, 32'd1);
        chk("mid_credits", {29'd0, credits}, 32'd3);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_send", {31'd0, link.send_out}, 32'd0);
        chk("async_credits", {29'd0, credits}, 32'd4);
        chk("async_pkt", {31'd0, pkt_active}, 32'd0);
        chk("async_err", {31'd0, credit_err}, 32'd0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        tick();
        chk("post_send", {31'd0, link.send_out}, 32'd1);
        chk("post_data", link.data_out, 32'h55);
        chk("post_dest", {31'd0, link.dest_out}, 32'd0);
        chk("post_tail", {31'd0, link.is_tail_out}, 32'd1);
        chk("post_pkt", {31'd0, pkt_active}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("post_refill", {29'd0, credits}, 32'd4);

        // Streaming 2-flit packets with credits looped back one cycle after send
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h100 + k, k[1], k[0], link.send_out);
            tick();
            chk("stream_send", {31'd0, link.send_out}, 32'd1);
            chk("stream_data", link.data_out, 32'h100 + k);
            chk("stream_dest", {31'd0, link.dest_out}, {31'd0, k[1]});
            chk("stream_credits", {29'd0, credits}, 32'd3);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, link.send_out);
        tick();
        chk("stream_end_credits", {29'd0, credits}, 32'd4);
        chk("stream_end_err", {31'd0, credit_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
